// File: rtl/wb_cmd_master_pkg.sv
// wb_cmd_master_pkg: FSM state encoding, status codes and command bit positions
package wb_cmd_master_pkg;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_WDATA = 3'd2;
  localparam logic [2:0] S_BUS   = 3'd3;
  localparam logic [2:0] S_STAT  = 3'd4;
  localparam logic [2:0] S_RDATA = 3'd5;
  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_TIMEOUT = 8'h01;
  localparam logic [7:0] ST_BADCMD  = 8'h02;
  localparam int CMD_WE_BIT = 7;
endpackage

// File: rtl/wb_cmd_master_resp.sv
// wb_cmd_master_resp: 5-byte load-then-shift response register, LSB first, valid/ready output
module wb_cmd_master_resp (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        len5,
  input  logic [39:0] din,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        last
);
  logic [39:0] sh;
  logic [2:0]  rem;
  // load a status (+ read data) frame, then shift one byte out per accept
  always_ff @(posedge clk) begin
    if (!rst) begin
      sh  <= '0;
      rem <= '0;
    end else if (load) begin
      sh  <= din;
      rem <= len5 ? 3'd5 : 3'd1;
    end else if (out_valid && out_ready) begin
      sh  <= {8'h00, sh[39:8]};
      rem <= rem - 3'd1;
    end
  end
  assign out_data  = sh[7:0];
  assign out_valid = rem != 3'd0;
  assign last      = out_valid && out_ready && rem == 3'd1;
endmodule

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: byte-stream command to Wishbone single-transaction initiator; WB_CMD_MASTER_TIMEOUT_EN adds an ack timeout
module wb_cmd_master
  import wb_cmd_master_pkg::*;
#(
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  wb_addr,
  output logic [31:0] wb_wdata,
  input  logic [31:0] wb_rdata,
  output logic        wb_we,
  output logic        wb_cyc,
  input  logic        wb_ack,
  output logic        busy
);
  logic [2:0] state;
  logic [1:0] idx;
  logic       rd_ok, bad, expire, load, len5, last;
  logic [7:0] status;
  assign bad      = in_data[6:0] != 7'd0;
  assign in_ready = rst && (state == S_IDLE || state == S_ADDR || state == S_WDATA);
  assign busy     = state != S_IDLE;
  assign load     = (state == S_IDLE && in_valid && in_ready && bad) || (state == S_BUS && (wb_ack || expire));
  assign len5     = state == S_BUS && wb_ack && !wb_we;
  assign status   = state == S_IDLE ? ST_BADCMD : wb_ack ? ST_OK : ST_TIMEOUT;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cnt;
  // count BUS cycles; zero whenever outside BUS so each transaction starts fresh
  always_ff @(posedge clk) begin
    if (!rst) cnt <= '0;
    else cnt <= state == S_BUS ? cnt + 1'b1 : '0;
  end
  assign expire = state == S_BUS && !wb_ack && cnt == TIMEOUT_W'(TIMEOUT - 1);
`else
  logic unused_tmo;
  assign unused_tmo = |{TIMEOUT_W, TIMEOUT};
  assign expire = 1'b0;
`endif
  // command parse, bus cycle and response sequencing
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      wb_cyc   <= 1'b0;
      wb_we    <= 1'b0;
      wb_addr  <= '0;
      wb_wdata <= '0;
      idx      <= '0;
      rd_ok    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          rd_ok <= 1'b0;
          state <= bad ? S_STAT : S_ADDR;
          if (!bad) wb_we <= in_data[CMD_WE_BIT];
        end
        S_ADDR: if (in_valid) begin
          wb_addr <= in_data;
          idx     <= '0;
          wb_cyc  <= !wb_we;
          state   <= wb_we ? S_WDATA : S_BUS;
        end
        S_WDATA: if (in_valid) begin
          wb_wdata[{idx, 3'b000} +: 8] <= in_data;
          idx <= idx + 2'd1;
          if (idx == 2'd3) begin
            wb_cyc <= 1'b1;
            state  <= S_BUS;
          end
        end
        S_BUS: if (wb_ack || expire) begin
          wb_cyc <= 1'b0;
          rd_ok  <= wb_ack && !wb_we;
          state  <= S_STAT;
        end
        S_STAT: if (out_valid && out_ready) state <= rd_ok ? S_RDATA : S_IDLE;
        S_RDATA: if (last) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
  wb_cmd_master_resp u_resp (
    .clk(clk),
    .rst(rst),
    .load(load),
    .len5(len5),
    .din({wb_rdata, status}),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .last(last)
  );
endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: scoreboard bench with a register-file slave and a transaction-level reference model
module tb_wb_cmd_master;
  logic        clk = 1'b0, rst = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0, in_ready;
  logic [7:0]  out_data;
  logic        out_valid, out_ready = 1'b0;
  logic [7:0]  wb_addr;
  logic [31:0] wb_wdata, wb_rdata;
  logic        wb_we, wb_cyc, wb_ack = 1'b0, busy;
  always #5 clk = ~clk;
  wb_cmd_master #(.TIMEOUT_W(8), .TIMEOUT(10)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_rdata(wb_rdata), .wb_we(wb_we),
    .wb_cyc(wb_cyc), .wb_ack(wb_ack), .busy(busy)
  );
  int total = 0, bad = 0;
  logic [7:0]  exp_q[$];
  logic [40:0] bus_q[$];
  logic [31:0] ref_mem[256];
  logic [31:0] smem[256];
  int mode = 1, ack_dly = 0, wait_c = 0, cyc_tot = 0;
  bit no_ack = 1'b0, exp_tmo = 1'b0, prev_stall = 1'b0, prev_cyc = 1'b0;
  logic [7:0] prev_data = 8'h00;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // slave: register file, acks after ack_dly wait cycles, never two acks in a row
  always @(posedge clk) begin
    if (!rst) begin
      wb_ack <= 1'b0;
      wait_c <= 0;
    end else begin
      wait_c <= (wb_cyc && !wb_ack) ? wait_c + 1 : 0;
      wb_ack <= wb_cyc && !wb_ack && !no_ack && wait_c >= ack_dly;
      if (wb_cyc && wb_ack && wb_we) smem[wb_addr] <= wb_wdata;
    end
  end
  assign wb_rdata = wb_ack ? smem[wb_addr] : 32'hDEADBEEF;
  // response monitor: drives out_ready, pops the scoreboard on each accept, checks stall stability
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
      out_ready = 1'b0;
    end else begin
      if (prev_stall) chk("out_hold", {out_valid, out_data}, {1'b1, prev_data});
      out_ready = mode == 0 ? ($urandom_range(0, 3) != 0) : (mode == 1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL resp_unexpected: got %0h expected none", out_data);
        end else chk("resp", out_data, exp_q.pop_front());
      end
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
    end
  end
  // bus monitor: address/data/we held against the expected transaction while cyc is high
  always @(negedge clk) begin
    if (!rst) prev_cyc = 1'b0;
    else begin
      if (wb_cyc) begin
        cyc_tot++;
        if (bus_q.size() == 0) begin
          total++; bad++;
          $display("FAIL bus_unexpected: got addr %0h expected no cycle", wb_addr);
        end else chk("bus", {wb_we, wb_addr, wb_we ? wb_wdata : 32'h0}, bus_q[0]);
      end else if (prev_cyc && bus_q.size() != 0) void'(bus_q.pop_front());
      prev_cyc = wb_cyc;
    end
  end
  task automatic send_byte(input logic [7:0] b, input bit rnd);
    repeat (rnd ? $urandom_range(0, 2) : 0) @(negedge clk);
    in_data = b;
    in_valid = 1'b1;
    for (int t = 0; !in_ready; t++) begin
      if (t > 3000) begin
        $display("FAIL in_ready_wait: got 0 expected 1");
        $fatal(1);
      end
      @(negedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  // kind 0 read, 1 write, 2 bad command (d[7:0] is the command byte)
  task automatic issue(input int kind, input logic [7:0] a, input logic [31:0] d, input bit rnd);
    if (kind == 2) begin
      exp_q.push_back(8'h02);
      send_byte(d[7:0], rnd);
    end else if (kind == 1) begin
      ref_mem[a] = d;
      exp_q.push_back(8'h00);
      bus_q.push_back({1'b1, a, d});
      send_byte(8'h80, rnd);
      send_byte(a, rnd);
      for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], rnd);
    end else begin
      if (exp_tmo) exp_q.push_back(8'h01);
      else begin
        exp_q.push_back(8'h00);
        for (int i = 0; i < 4; i++) exp_q.push_back(ref_mem[a][8*i +: 8]);
      end
      bus_q.push_back({1'b0, a, 32'h0});
      send_byte(8'h00, rnd);
      send_byte(a, rnd);
    end
  endtask
  task automatic drain();
    for (int t = 0; exp_q.size() != 0 || bus_q.size() != 0 || busy; t++) begin
      if (t > 3000) begin
        total++; bad++;
        $display("FAIL drain: got %0d bytes pending expected 0", exp_q.size());
        exp_q.delete();
        bus_q.delete();
        break;
      end
      @(negedge clk);
    end
  endtask
  task automatic wait_for(input string name, input bit cyc_not_valid);
    for (int t = 0; cyc_not_valid ? !wb_cyc : !out_valid; t++) begin
      if (t > 200) begin
        total++; bad++;
        $display("FAIL %s: got 0 expected 1", name);
        break;
      end
      @(negedge clk);
    end
  endtask
  initial begin
    int c0, r;
    logic [31:0] d;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_cyc_we_busy", {wb_cyc, wb_we, busy}, 0);
    chk("rst_data", {out_data, wb_addr, wb_wdata}, 0);
    rst = 1'b1;
    @(negedge clk);
    c0 = cyc_tot;
    issue(1, 8'h00, 32'h5, 1'b0);
    drain();
    chk("wr_cyc_len", cyc_tot - c0, 2);
    issue(1, 8'h07, 32'h12345678, 1'b0);
    drain();
    c0 = cyc_tot;
    issue(0, 8'h07, 32'h0, 1'b0);
    drain();
    chk("rd_cyc_len", cyc_tot - c0, 2);
    issue(2, 8'h00, 32'h41, 1'b0);
    issue(0, 8'h07, 32'h0, 1'b0);
    drain();
    c0 = cyc_tot;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
    no_ack = 1'b1;
    exp_tmo = 1'b1;
    issue(0, 8'h04, 32'h0, 1'b0);
    drain();
    chk("tmo_cyc_len", cyc_tot - c0, 10);
    no_ack = 1'b0;
    exp_tmo = 1'b0;
`else
    ack_dly = 30;
    issue(0, 8'h07, 32'h0, 1'b0);
    drain();
    chk("slow_ack_cyc_len", cyc_tot - c0, 32);
    ack_dly = 0;
`endif
    no_ack = 1'b1;
    issue(0, 8'h07, 32'h0, 1'b0);
    wait_for("bus_wait", 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_bus_cyc", {wb_cyc, out_valid, busy}, 0);
    exp_q.delete();
    bus_q.delete();
    @(negedge clk);
    rst = 1'b1;
    no_ack = 1'b0;
    @(negedge clk);
    issue(0, 8'h07, 32'h0, 1'b0);
    drain();
    mode = 2;
    issue(0, 8'h07, 32'h0, 1'b0);
    wait_for("stat_wait", 1'b0);
    #2 mode = 1;
    @(negedge clk);
    #2 mode = 2;
    @(negedge clk);
    chk("rdata_busy", {busy, out_valid}, 2'b11);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rdata_valid", {out_valid, wb_cyc, busy}, 0);
    exp_q.delete();
    bus_q.delete();
    @(negedge clk);
    rst = 1'b1;
    mode = 1;
    @(negedge clk);
    issue(0, 8'h07, 32'h0, 1'b0);
    drain();
    mode = 0;
    for (int a = 0; a < 16; a++) issue(1, 8'(a), $urandom, 1'b1);
    for (int n = 0; n < 1000; n++) begin
      r = $urandom_range(0, 9);
      ack_dly = $urandom_range(0, 3);
      d = $urandom;
      if (r < 2) d[7:0] = {1'($urandom_range(0, 1)), 7'($urandom_range(1, 127))};
      issue(r < 2 ? 2 : r < 6 ? 1 : 0, 8'($urandom_range(0, 15)), d, 1'b1);
    end
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_cmd_master.md
# wb_cmd_master

Wishbone initiator that executes single read/write transactions from a byte-stream command channel (USB bulk endpoint or debug UART) and returns status and read data as a byte stream. It drives the same 8-bit-address, 32-bit-data, `cyc`/`ack` Wishbone bus that the tracer peripherals respond on. This gives host tools register access (boot control, tick select, counters) without the soft CPU.

## Interface
- `TIMEOUT_W`, default 8: width of the ack-timeout counter.
- `TIMEOUT`, default 255: number of cycles `wb_cyc` may stay high without `wb_ack` (1..2^TIMEOUT_W-1).
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `in_data`  in  8  command byte.
- `in_valid`  in  1  command byte present.
- `in_ready`  out  1  command byte accepted when `in_valid & in_ready`.
- `out_data`  out  8  response byte.
- `out_valid`  out  1  response byte present; held with stable data until accepted.
- `out_ready`  in  1  response byte accepted when `out_valid & out_ready`.
- `wb_addr`  out  8  bus address.
- `wb_wdata`  out  32  write data.
- `wb_rdata`  in  32  read data; sampled only in the cycle `wb_ack` is high.
- `wb_we`  out  1  write strobe qualifier.
- `wb_cyc`  out  1  cycle active.
- `wb_ack`  in  1  slave acknowledge.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Command format:
  - Byte 0 is CMD: bit 7 = WE, bits 6:0 must be 0.
  - Byte 1 is ADDR.
  - Writes only: bytes 2..5 are WDATA, LSB first.
- Response format:
  - First byte is STATUS: 0x00 OK, 0x01 TIMEOUT, 0x02 BADCMD.
  - Successful reads only: 4 RDATA bytes follow, LSB first.
- FSM states: IDLE, ADDR, WDATA, BUS, STAT, RDATA.
- IDLE:
  - accept CMD.
  - If bits 6:0 are nonzero: go to STAT with BADCMD. No further bytes are consumed, so the host resynchronises on the next byte.
  - Otherwise: latch WE, go to ADDR.
- ADDR: accept byte into `wb_addr`. Go to WDATA if WE is set, else BUS.
- WDATA:
  - Accept 4 bytes into `wb_wdata` [7:0], [15:8], [23:16], [31:24]. A 2-bit byte index wraps 3→0.
  - Go to BUS after the 4th byte.
- BUS:
  - `wb_cyc`=1; `wb_we` = latched WE.
  - On `wb_ack`: capture `wb_rdata` (reads only), deassert `wb_cyc` at that edge, go to STAT with OK.
- STAT:
  - Present STATUS.
  - On accept: go to RDATA if read with OK, else IDLE.
- RDATA: present the 4 captured bytes LSB first. Go to IDLE after the 4th accept.
- `in_ready` = 1 only in IDLE, ADDR, WDATA. `out_valid` = 1 only in STAT, RDATA.
- `wb_ack` outside BUS is ignored.
- `wb_addr`/`wb_wdata`/`wb_we` are stable for the whole time `wb_cyc` is high.
- Reset values:
  - `in_ready`, `out_valid`, `wb_cyc`, `wb_we`, `busy` = 0.
  - `out_data`, `wb_addr`, `wb_wdata` = 0.
  - State is IDLE.
- Reset mid-operation: `wb_cyc` low at the next edge and any partial command is discarded. No response is emitted.

## Timing
- `wb_cyc` rises on the edge after the last command byte is accepted.
- `wb_cyc` falls on the edge that samples `wb_ack`=1, so it is never high in the cycle after an ack. This is required by slaves that generate `ack <= cyc & ~ack`.
- With a one-cycle-ack slave:
  - Command-end edge E: `wb_cyc` high from E.
  - `wb_ack` sampled at E+1.
  - STATUS valid from E+2.
  - At full throughput a read takes 2 + 2 + 5 cycles end to end.
- Back-to-back: the next CMD can be accepted in the cycle after the final response byte is accepted.
- `out_data`/`out_valid` are registered. Stalls on `out_ready` hold them unchanged.
- No combinational path from `out_ready` to `in_ready`.

## Configuration
- `WB_CMD_MASTER_TIMEOUT_EN` defined:
  - A counter clears on entry to BUS and increments each BUS cycle without ack.
  - When it reaches `TIMEOUT`: `wb_cyc` drops at that edge, STATUS = TIMEOUT, no RDATA.
  - An ack in the same cycle as expiry wins (OK).
- Not defined: no counter. BUS waits indefinitely, and STATUS 0x01 is never produced.

## Structure
- Package `wb_cmd_master_pkg` holds:
  - the state encoding (localparams);
  - the status codes `ST_OK`/`ST_TIMEOUT`/`ST_BADCMD`;
  - `CMD_WE_BIT`.
- One sub-module, `wb_cmd_master_resp`: a 5-byte load-then-shift response register with a valid/ready output, loaded with {rdata, status} and length 1 or 5.

## Test plan
- Write: 0x80,0x00,0x05,0x00,0x00,0x00 to a 1-cycle-ack slave model → `wb_addr`=0x00, `wb_wdata`=0x00000005, `wb_we`=1; `wb_cyc` high exactly 2 cycles; response 0x00 only.
- Read: 0x00,0x07 with slave returning 0x12345678 → response 0x00,0x78,0x56,0x34,0x12; `wb_we`=0 throughout.
- Bad command: 0x41 → response 0x02; the next byte 0x00 is treated as a fresh CMD.
- Timeout (macro defined, `TIMEOUT`=10, slave never acks): read 0x00,0x04 → `wb_cyc` high exactly 10 cycles, response 0x01. With the macro undefined, `wb_cyc` stays high until ack.
- Random `in_valid`/`out_ready` stalls over 1000 mixed commands against a register-file model → all responses match the model; `out_data` stable whenever `out_valid & ~out_ready`.
- Reset asserted while in BUS and in RDATA → `wb_cyc`/`out_valid` low next cycle, then a normal read completes correctly.
